// File: rtl/vga_text_ctrl_if.sv
// vga_text_ctrl_if: CPU register bus plus VGA text-RAM write port.
//
// Handshake: cpu_we and cpu_re are one-cycle strobes with no ready/stall.
// The controller never back-pressures. A CHAR or CMD write that arrives
// while busy is high is dropped and recorded in the sticky overrun flag.
// ram_wren qualifies ram_addr/ram_data in the same cycle; the RAM always
// accepts. dbg_state mirrors the sequencer state encoding.
interface vga_text_ctrl_if;
  logic [2:0]  cpu_addr;
  logic [7:0]  cpu_din;
  logic        cpu_we;
  logic        cpu_re;
  logic [7:0]  cpu_dout;
  logic        busy;
  logic [12:0] ram_addr;
  logic [7:0]  ram_data;
  logic        ram_wren;
  logic [2:0]  dbg_state;

  modport slave (
    input  cpu_addr, cpu_din, cpu_we, cpu_re,
    output cpu_dout, busy, ram_addr, ram_data, ram_wren, dbg_state
  );

  modport master (
    output cpu_addr, cpu_din, cpu_we, cpu_re,
    input  cpu_dout, busy, ram_addr, ram_data, ram_wren, dbg_state
  );
endinterface

// File: rtl/vga_text_ctrl.sv
// vga_text_ctrl: text console sequencer in front of the VGA char/colour RAM.
// Each CHAR write becomes a character-plane write, then a colour-plane write,
// then a cursor advance. A fill engine handles clear-screen, clear-line and
// the line clear that follows every row change.
// Optional macro VGA_TEXT_CTRL_CTRLCHARS_EN: interpret CHAR bytes below 0x20
// (newline, CR, backspace, form feed) instead of drawing them.
module vga_text_ctrl #(
  parameter int          COLS      = 50,
  parameter int          ROWS      = 30,
  parameter logic [7:0]  ATTR_RST  = 8'hF0,
  parameter logic [7:0]  FILL_CHAR = 8'h20
) (
  input  logic            clk_20MHz,
  input  logic            reset,
  vga_text_ctrl_if.slave  bus
);

  localparam logic [5:0] COLS_M1 = 6'(COLS - 1);
  localparam logic [5:0] ROWS_M1 = 6'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PUT_C  = 3'd1,
    S_PUT_A  = 3'd2,
    S_FILL_C = 3'd3,
    S_FILL_A = 3'd4,
    S_ADV    = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] cur_x_q, cur_x_d;
  logic [5:0] cur_y_q, cur_y_d;
  logic [7:0] attr_q, attr_d;
  logic [7:0] char_q, char_d;     // byte being put (or control code)
  logic [7:0] wattr_q, wattr_d;   // attribute latched for the running op
  logic [5:0] wrow_q, wrow_d;     // write position of the running op
  logic [5:0] wcol_q, wcol_d;
  logic [5:0] fend_q, fend_d;     // last row the fill covers
  logic       fscr_q, fscr_d;     // fill is a full clear-screen
  logic       done_q, done_d;     // one trailing busy cycle after a fill
  logic       ovr_q, ovr_d;
  logic [7:0] dout_q, dout_d;

  logic       busy_w;
  logic       wr_char, wr_cmd;
  logic       in_ctrl;            // incoming CHAR byte is a control code
  logic       cur_ctrl;           // latched CHAR byte is a control code
  logic [5:0] nl_row;

`ifdef VGA_TEXT_CTRL_CTRLCHARS_EN
  assign in_ctrl  = (bus.cpu_din < 8'h20);
  assign cur_ctrl = (char_q < 8'h20);
`else
  assign in_ctrl  = 1'b0;
  assign cur_ctrl = 1'b0;
`endif

  assign busy_w  = (state_q != S_IDLE) || done_q;
  assign wr_char = bus.cpu_we && (bus.cpu_addr == 3'd0);
  assign wr_cmd  = bus.cpu_we && (bus.cpu_addr == 3'd4);
  assign nl_row  = (wrow_q == ROWS_M1) ? 6'd0 : wrow_q + 6'd1;

  // Sequencer next state, cursor/attribute updates, overrun and read data.
  always_comb begin
    state_d = state_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    attr_d  = attr_q;
    char_d  = char_q;
    wattr_d = wattr_q;
    wrow_d  = wrow_q;
    wcol_d  = wcol_q;
    fend_d  = fend_q;
    fscr_d  = fscr_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    dout_d  = dout_q;

    case (state_q)
      S_IDLE: begin
        if (!done_q) begin
          if (wr_char) begin
            char_d  = bus.cpu_din;
            wattr_d = attr_q;
            wrow_d  = cur_y_q;
            wcol_d  = cur_x_q;
            state_d = in_ctrl ? S_ADV : S_PUT_C;
          end else if (wr_cmd && bus.cpu_din == 8'h01) begin
            wattr_d = attr_q;
            wrow_d  = 6'd0;
            wcol_d  = 6'd0;
            fend_d  = ROWS_M1;
            fscr_d  = 1'b1;
            state_d = S_FILL_C;
          end else if (wr_cmd && bus.cpu_din == 8'h02) begin
            wattr_d = attr_q;
            wrow_d  = cur_y_q;
            wcol_d  = 6'd0;
            fend_d  = cur_y_q;
            fscr_d  = 1'b0;
            state_d = S_FILL_C;
          end
        end
      end
      S_PUT_C: state_d = S_PUT_A;
      S_PUT_A: state_d = S_ADV;
      S_ADV: begin
        state_d = S_IDLE;
        if (cur_ctrl) begin
          case (char_q)
            8'h0A: begin
              cur_x_d = 6'd0;
              cur_y_d = nl_row;
              wattr_d = attr_q;
              wrow_d  = nl_row;
              wcol_d  = 6'd0;
              fend_d  = nl_row;
              fscr_d  = 1'b0;
              state_d = S_FILL_C;
            end
            8'h0D: cur_x_d = 6'd0;
            8'h08: cur_x_d = (wcol_q == 6'd0) ? 6'd0 : wcol_q - 6'd1;
            8'h0C: begin
              wattr_d = attr_q;
              wrow_d  = 6'd0;
              wcol_d  = 6'd0;
              fend_d  = ROWS_M1;
              fscr_d  = 1'b1;
              state_d = S_FILL_C;
            end
            default: ;
          endcase
        end else if (wcol_q == COLS_M1) begin
          // End of row: wrap to the next row and clear it.
          cur_x_d = 6'd0;
          cur_y_d = nl_row;
          wattr_d = attr_q;
          wrow_d  = nl_row;
          wcol_d  = 6'd0;
          fend_d  = nl_row;
          fscr_d  = 1'b0;
          state_d = S_FILL_C;
        end else begin
          cur_x_d = wcol_q + 6'd1;
          cur_y_d = wrow_q;
        end
      end
      S_FILL_C: state_d = S_FILL_A;
      S_FILL_A: begin
        if (wcol_q != COLS_M1) begin
          wcol_d  = wcol_q + 6'd1;
          state_d = S_FILL_C;
        end else if (wrow_q != fend_q) begin
          wcol_d  = 6'd0;
          wrow_d  = wrow_q + 6'd1;
          state_d = S_FILL_C;
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          cur_x_d = 6'd0;
          if (fscr_q) cur_y_d = 6'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Register writes land last so a CPU write wins over a same-cycle update.
    if (bus.cpu_we) begin
      case (bus.cpu_addr)
        3'd1: attr_d  = bus.cpu_din;
        3'd2: cur_x_d = (bus.cpu_din >= 8'(COLS)) ? COLS_M1 : bus.cpu_din[5:0];
        3'd3: cur_y_d = (bus.cpu_din >= 8'(ROWS)) ? ROWS_M1 : bus.cpu_din[5:0];
        default: ;
      endcase
    end

    if (bus.cpu_re) begin
      case (bus.cpu_addr)
        3'd1:    dout_d = attr_q;
        3'd2:    dout_d = {2'b00, cur_x_q};
        3'd3:    dout_d = {2'b00, cur_y_q};
        3'd5:    dout_d = {6'b0, ovr_q, busy_w};
        default: dout_d = 8'h00;
      endcase
      if (bus.cpu_addr == 3'd5) ovr_d = 1'b0;
    end
    // Setting overrun takes priority over the clear-on-read above.
    if ((wr_char || wr_cmd) && busy_w) ovr_d = 1'b1;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_20MHz) begin
    if (reset) begin
      state_q <= S_IDLE;
      cur_x_q <= 6'd0;
      cur_y_q <= 6'd0;
      attr_q  <= ATTR_RST;
      char_q  <= 8'h00;
      wattr_q <= 8'h00;
      wrow_q  <= 6'd0;
      wcol_q  <= 6'd0;
      fend_q  <= 6'd0;
      fscr_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      dout_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      attr_q  <= attr_d;
      char_q  <= char_d;
      wattr_q <= wattr_d;
      wrow_q  <= wrow_d;
      wcol_q  <= wcol_d;
      fend_q  <= fend_d;
      fscr_q  <= fscr_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      dout_q  <= dout_d;
    end
  end

  // RAM write port decoded from state; quiet (all zero) outside write states.
  always_comb begin
    bus.ram_wren = 1'b0;
    bus.ram_addr = 13'd0;
    bus.ram_data = 8'h00;
    case (state_q)
      S_PUT_C: begin
        bus.ram_wren = 1'b1;
        bus.ram_addr = {1'b0, wrow_q, wcol_q};
        bus.ram_data = char_q;
      end
      S_PUT_A: begin
        bus.ram_wren = 1'b1;
        bus.ram_addr = {1'b1, wrow_q, wcol_q};
        bus.ram_data = wattr_q;
      end
      S_FILL_C: begin
        bus.ram_wren = 1'b1;
        bus.ram_addr = {1'b0, wrow_q, wcol_q};
        bus.ram_data = FILL_CHAR;
      end
      S_FILL_A: begin
        bus.ram_wren = 1'b1;
        bus.ram_addr = {1'b1, wrow_q, wcol_q};
        bus.ram_data = wattr_q;
      end
      default: ;
    endcase
  end

  assign bus.cpu_dout  = dout_q;
  assign bus.busy      = busy_w;
  assign bus.dbg_state = state_q;

endmodule
